lcd_output_stage: RTL and testbench

Parametrised LCD output stage between the frame-buffer/text-overlay pixel path and the GPIO panel pins. Generates the pixel clock and tick from the system clock, aligns control signals with late-arriving colour data, and composites the text overlay with a selectable mode. Adds a panel power-sequencing FSM and a PWM backlight. Both replace the hard-wired display-on and backlight pins.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_output_stage_if.sv | 29 ++
 rtl/lcd_power_seq.sv | 101 ++++++++++
 rtl/lcd_output_stage.sv | 147 ++++++++++++++
 tb/tb_lcd_output_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD output stage: overlay compositing modes and
// panel power-sequencer states.
package lcd_pkg;

  typedef enum logic [1:0] {
    OVL_OFF    = 2'd0,
    OVL_WHITE  = 2'd1,
    OVL_INVERT = 2'd2,
    OVL_BLEND  = 2'd3
  } ovl_mode_t;

  typedef enum logic [1:0] {
    PWR_OFF      = 2'd0,
    PWR_PANEL_ON = 2'd1,
    PWR_RUN      = 2'd2,
    PWR_BL_OFF   = 2'd3
  } pwr_state_t;

endpackage

// File: rtl/lcd_output_stage_if.sv
// Pixel bus into the output stage (timing + late colour/overlay) and the
// registered panel-side colour/sync bus coming out of it.
interface lcd_output_stage_if #(
  parameter int COLOR_BITS = 8
);
  logic                  data_enable_in;
  logic                  hs_n_in;
  logic                  vs_n_in;
  logic [COLOR_BITS-1:0] fb_red;
  logic [COLOR_BITS-1:0] fb_green;
  logic [COLOR_BITS-1:0] fb_blue;
  logic                  overlay_bw;
  logic [COLOR_BITS-1:0] lcd_red;
  logic [COLOR_BITS-1:0] lcd_green;
  logic [COLOR_BITS-1:0] lcd_blue;
  logic                  lcd_data_enable;
  logic                  lcd_hs_n;
  logic                  lcd_vs_n;

  modport master (
    output data_enable_in, hs_n_in, vs_n_in, fb_red, fb_green, fb_blue, overlay_bw,
    input  lcd_red, lcd_green, lcd_blue, lcd_data_enable, lcd_hs_n, lcd_vs_n
  );

  modport slave (
    input  data_enable_in, hs_n_in, vs_n_in, fb_red, fb_green, fb_blue, overlay_bw,
    output lcd_red, lcd_green, lcd_blue, lcd_data_enable, lcd_hs_n, lcd_vs_n
  );
endinterface

// File: rtl/lcd_power_seq.sv
// Panel power sequencer (panel-on -> backlight-on -> backlight-off -> panel-off)
// with a PWM backlight whose duty only changes at the start of a PWM period.
module lcd_power_seq
  import lcd_pkg::*;
#(
  parameter int PWM_BITS          = 8,
  parameter int POWER_DELAY_TICKS = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                display_on_req,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                lcd_display_on,
  output logic                lcd_backlight,
  output logic [1:0]          power_state,
  output logic                ready
);

  localparam int CNT_W = (POWER_DELAY_TICKS > 1) ? $clog2(POWER_DELAY_TICKS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(POWER_DELAY_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = {PWM_BITS{1'b1}};

  pwr_state_t          state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [PWM_BITS-1:0] pwm_r, pwm_next_s;
  logic [PWM_BITS-1:0] duty_r, duty_next_s;
  logic                delay_done_s;
  logic                backlight_next_s;
  logic                display_on_r, backlight_r, ready_r;

  // Next-state logic: requests act on any clock, delay expiry only on a tick.
  always_comb begin
    state_next_s = state_r;
    delay_done_s = tick && (cnt_r == CNT_LAST);
    case (state_r)
      PWR_OFF: begin
        if (display_on_req) state_next_s = PWR_PANEL_ON;
        else                state_next_s = PWR_OFF;
      end
      PWR_PANEL_ON: begin
        if (!display_on_req)   state_next_s = PWR_OFF;
        else if (delay_done_s) state_next_s = PWR_RUN;
        else                   state_next_s = PWR_PANEL_ON;
      end
      PWR_RUN: begin
        if (!display_on_req) state_next_s = PWR_BL_OFF;
        else                 state_next_s = PWR_RUN;
      end
      PWR_BL_OFF: begin
        if (display_on_req)    state_next_s = PWR_RUN;
        else if (delay_done_s) state_next_s = PWR_OFF;
        else                   state_next_s = PWR_BL_OFF;
      end
      default: state_next_s = PWR_OFF;
    endcase
  end

  // Delay counter restarts on every state change; PWM duty reloads on wrap.
  always_comb begin
    cnt_next_s  = cnt_r;
    pwm_next_s  = pwm_r;
    duty_next_s = duty_r;
    if (state_next_s != state_r) cnt_next_s = {CNT_W{1'b0}};
    else if (tick)               cnt_next_s = cnt_r + CNT_W'(1);
    else                         cnt_next_s = cnt_r;
    if (tick) pwm_next_s = pwm_r + PWM_BITS'(1);
    else      pwm_next_s = pwm_r;
    if (tick && (pwm_next_s == {PWM_BITS{1'b0}})) duty_next_s = brightness;
    else                                          duty_next_s = duty_r;
    backlight_next_s = (state_next_s == PWR_RUN) &&
                       ((duty_next_s == DUTY_FULL) || (pwm_next_s < duty_next_s));
  end

  // State, counters and registered panel power outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= PWR_OFF;
      cnt_r        <= {CNT_W{1'b0}};
      pwm_r        <= {PWM_BITS{1'b0}};
      duty_r       <= {PWM_BITS{1'b0}};
      display_on_r <= 1'b0;
      backlight_r  <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      pwm_r        <= pwm_next_s;
      duty_r       <= duty_next_s;
      display_on_r <= (state_next_s != PWR_OFF);
      backlight_r  <= backlight_next_s;
      ready_r      <= (state_next_s == PWR_RUN);
    end
  end

  assign lcd_display_on = display_on_r;
  assign lcd_backlight  = backlight_r;
  assign power_state    = state_r;
  assign ready          = ready_r;

endmodule

// File: rtl/lcd_output_stage.sv
// LCD output stage: pixel clock divider, sync/DE alignment to late colour data,
// text-overlay compositing and panel power sequencing. All outputs are flops.
module lcd_output_stage
  import lcd_pkg::*;
#(
  parameter int COLOR_BITS        = 8,
  parameter int CLOCK_DIVIDE      = 2,
  parameter int PIPE_DELAY        = 1,
  parameter int PWM_BITS          = 8,
  parameter int POWER_DELAY_TICKS = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                lcd_tick,
  output logic                lcd_clk,
  lcd_output_stage_if.slave   pix,
  input  logic [1:0]          overlay_mode,
  input  logic                display_on_req,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                lcd_display_on,
  output logic                lcd_backlight,
  output logic [1:0]          power_state,
  output logic                ready
);

  localparam int DIV_W = $clog2(CLOCK_DIVIDE);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(CLOCK_DIVIDE / 2);
  localparam logic [COLOR_BITS-1:0] C_FULL   = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] C_ZERO   = {COLOR_BITS{1'b0}};

  logic [DIV_W-1:0]      div_r, div_next_s;
  logic                  tick_r, clk_r;
  logic [PIPE_DELAY-1:0] de_dly_r, hs_dly_r, vs_dly_r;
  logic                  de_out_s;
  logic [COLOR_BITS-1:0] red_s, green_s, blue_s;
  logic [COLOR_BITS-1:0] red_r, green_r, blue_r;
  logic                  de_r, hs_r, vs_r;

  function automatic logic [COLOR_BITS-1:0] compose(
    input logic [COLOR_BITS-1:0] fb,
    input logic                  ovl,
    input logic [1:0]            mode,
    input logic                  en
  );
    if (!en) return C_ZERO;
    else if (!ovl) return fb;
    else begin
      case (mode)
        OVL_WHITE:  return C_FULL;
        OVL_INVERT: return ~fb;
        // Blend toward white needs one extra bit so the carry is not lost.
        OVL_BLEND:  return COLOR_BITS'(({1'b0, fb} + {1'b0, C_FULL}) >> 1);
        default:    return fb;
      endcase
    end
  endfunction

  // Divider phase counter wraps at CLOCK_DIVIDE-1.
  always_comb begin
    if (div_r == DIV_LAST) div_next_s = {DIV_W{1'b0}};
    else                   div_next_s = div_r + DIV_W'(1);
  end

  // Tick and pixel clock are decoded from the next phase so they line up with div_r.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
      clk_r  <= 1'b0;
    end else begin
      div_r  <= div_next_s;
      tick_r <= (div_next_s == DIV_LAST);
      clk_r  <= (div_next_s >= DIV_HALF);
    end
  end

  // Sync/DE delay lines, advanced once per pixel tick; sync idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de_dly_r <= {PIPE_DELAY{1'b0}};
      hs_dly_r <= {PIPE_DELAY{1'b1}};
      vs_dly_r <= {PIPE_DELAY{1'b1}};
    end else if (tick_r) begin
      for (int i = PIPE_DELAY - 1; i > 0; i--) begin
        de_dly_r[i] <= de_dly_r[i-1];
        hs_dly_r[i] <= hs_dly_r[i-1];
        vs_dly_r[i] <= vs_dly_r[i-1];
      end
      de_dly_r[0] <= pix.data_enable_in;
      hs_dly_r[0] <= pix.hs_n_in;
      vs_dly_r[0] <= pix.vs_n_in;
    end
  end

  // Colour compositing; pixels are blanked unless the panel is fully running.
  always_comb begin
    de_out_s = de_dly_r[PIPE_DELAY-1] & ready;
    red_s    = compose(pix.fb_red,   pix.overlay_bw, overlay_mode, de_out_s);
    green_s  = compose(pix.fb_green, pix.overlay_bw, overlay_mode, de_out_s);
    blue_s   = compose(pix.fb_blue,  pix.overlay_bw, overlay_mode, de_out_s);
  end

  // Panel-side output register, updated once per pixel tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de_r    <= 1'b0;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      red_r   <= C_ZERO;
      green_r <= C_ZERO;
      blue_r  <= C_ZERO;
    end else if (tick_r) begin
      de_r    <= de_out_s;
      hs_r    <= hs_dly_r[PIPE_DELAY-1];
      vs_r    <= vs_dly_r[PIPE_DELAY-1];
      red_r   <= red_s;
      green_r <= green_s;
      blue_r  <= blue_s;
    end
  end

  lcd_power_seq #(
    .PWM_BITS         (PWM_BITS),
    .POWER_DELAY_TICKS(POWER_DELAY_TICKS)
  ) u_power_seq (
    .clock         (clock),
    .reset_n       (reset_n),
    .tick          (tick_r),
    .display_on_req(display_on_req),
    .brightness    (brightness),
    .lcd_display_on(lcd_display_on),
    .lcd_backlight (lcd_backlight),
    .power_state   (power_state),
    .ready         (ready)
  );

  assign lcd_tick            = tick_r;
  assign lcd_clk             = clk_r;
  assign pix.lcd_data_enable = de_r;
  assign pix.lcd_hs_n        = hs_r;
  assign pix.lcd_vs_n        = vs_r;
  assign pix.lcd_red         = red_r;
  assign pix.lcd_green       = green_r;
  assign pix.lcd_blue        = blue_r;

endmodule

// File: tb/tb_lcd_output_stage.sv
// Self-checking bench for lcd_output_stage: divider, alignment, overlay modes,
// power sequencing, PWM backlight and asynchronous reset, with random pixel traffic.
module tb_lcd_output_stage;

  localparam int CB  = 8;
  localparam int CD  = 4;
  localparam int PD  = 2;
  localparam int PWB = 4;
  localparam int PDT = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           lcd_tick, lcd_clk;
  logic [1:0]     overlay_mode;
  logic           display_on_req;
  logic [PWB-1:0] brightness;
  logic           lcd_display_on, lcd_backlight, ready;
  logic [1:0]     power_state;

  lcd_output_stage_if #(.COLOR_BITS(CB)) pix_if ();

  lcd_output_stage #(
    .COLOR_BITS(CB), .CLOCK_DIVIDE(CD), .PIPE_DELAY(PD),
    .PWM_BITS(PWB), .POWER_DELAY_TICKS(PDT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .lcd_tick(lcd_tick), .lcd_clk(lcd_clk),
    .pix(pix_if), .overlay_mode(overlay_mode), .display_on_req(display_on_req),
    .brightness(brightness), .lcd_display_on(lcd_display_on),
    .lcd_backlight(lcd_backlight), .power_state(power_state), .ready(ready)
  );

  always #10 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned tick_cnt;
  logic        q_de[$], q_hs[$], q_vs[$];

  // Reference history: timing inputs seen at each tick edge (reset state is idle).
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= 0;
      q_de.delete(); q_hs.delete(); q_vs.delete();
      for (int i = 0; i < PD; i++) begin
        q_de.push_back(1'b0); q_hs.push_back(1'b1); q_vs.push_back(1'b1);
      end
    end else if (lcd_tick) begin
      tick_cnt <= tick_cnt + 1;
      q_de.push_back(pix_if.data_enable_in);
      q_hs.push_back(pix_if.hs_n_in);
      q_vs.push_back(pix_if.vs_n_in);
      if (q_de.size() > PD + 1) begin
        void'(q_de.pop_front()); void'(q_hs.pop_front()); void'(q_vs.pop_front());
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_colour(input logic [7:0] fb, input logic ovl,
                                            input logic [1:0] mode, input logic en);
    int v;
    if (!en) return 8'd0;
    if (!ovl || mode == 2'd0) return fb;
    case (mode)
      2'd1:    v = 255;
      2'd2:    v = 255 - int'(fb);
      default: v = (int'(fb) + 255) / 2;
    endcase
    return v[7:0];
  endfunction

  // Advance to just after the next tick edge.
  task automatic next_tick();
    int guard = 0;
    @(negedge clock);
    while (!lcd_tick && guard < 4 * CD) begin
      @(negedge clock);
      guard++;
    end
    if (!lcd_tick) check_eq("tick_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic pix_step(input logic de, input logic hs, input logic vs,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic ovl, input logic [1:0] mode, input logic run);
    logic exp_de;
    pix_if.data_enable_in = de;
    pix_if.hs_n_in        = hs;
    pix_if.vs_n_in        = vs;
    pix_if.fb_red         = r;
    pix_if.fb_green       = g;
    pix_if.fb_blue        = b;
    pix_if.overlay_bw     = ovl;
    overlay_mode          = mode;
    next_tick();
    exp_de = q_de[0] & run;
    check_eq("de",    pix_if.lcd_data_enable, exp_de);
    check_eq("hs_n",  pix_if.lcd_hs_n, q_hs[0]);
    check_eq("vs_n",  pix_if.lcd_vs_n, q_vs[0]);
    check_eq("red",   pix_if.lcd_red,   ref_colour(r, ovl, mode, exp_de));
    check_eq("green", pix_if.lcd_green, ref_colour(g, ovl, mode, exp_de));
    check_eq("blue",  pix_if.lcd_blue,  ref_colour(b, ovl, mode, exp_de));
  endtask

  task automatic rand_steps(input int n, input logic run);
    for (int i = 0; i < n; i++)
      pix_step(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom), 2'($urandom), run);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tick"}, lcd_tick, 1'b0);
    check_eq({tag, "_clk"},  lcd_clk, 1'b0);
    check_eq({tag, "_de"},   pix_if.lcd_data_enable, 1'b0);
    check_eq({tag, "_hs"},   pix_if.lcd_hs_n, 1'b1);
    check_eq({tag, "_vs"},   pix_if.lcd_vs_n, 1'b1);
    check_eq({tag, "_rgb"},  {pix_if.lcd_red, pix_if.lcd_green, pix_if.lcd_blue}, 24'd0);
    check_eq({tag, "_disp"}, lcd_display_on, 1'b0);
    check_eq({tag, "_bl"},   lcd_backlight, 1'b0);
    check_eq({tag, "_rdy"},  ready, 1'b0);
    check_eq({tag, "_ps"},   power_state, 2'd0);
  endtask

  task automatic wait_pwm(input int unsigned target);
    int guard = 0;
    while ((tick_cnt % 16) != target && guard < 20) begin
      next_tick();
      guard++;
    end
    check_eq("pwm_align", tick_cnt % 16, target);
  endtask

  task automatic count_high(input int n, input int exp, input string tag);
    int hi = 0;
    for (int i = 0; i < n; i++) begin
      next_tick();
      if (lcd_backlight) hi++;
    end
    check_eq(tag, hi, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ovl_exp [4];
    ovl_exp[0] = 24'h0080FF; ovl_exp[1] = 24'hFFFFFF;
    ovl_exp[2] = 24'hFF7F00; ovl_exp[3] = 24'h7FBFFF;
    reset_n = 1'b0; display_on_req = 1'b0; brightness = 4'd0; overlay_mode = 2'd0;
    pix_if.data_enable_in = 1'b0; pix_if.hs_n_in = 1'b1; pix_if.vs_n_in = 1'b1;
    pix_if.fb_red = 8'd0; pix_if.fb_green = 8'd0; pix_if.fb_blue = 8'd0;
    pix_if.overlay_bw = 1'b0;
    #35;
    check_reset_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Divider: phase i after release is i mod 4.
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      check_eq("div_tick", lcd_tick, (i % CD) == CD - 1);
      check_eq("div_clk",  lcd_clk,  (i % CD) >= CD / 2);
      check_eq("div_hs",   pix_if.lcd_hs_n, 1'b1);
    end

    // Panel off: sync still flows, DE and colour stay blank.
    rand_steps(10, 1'b0);
    check_eq("off_ps", power_state, 2'd0);
    check_eq("off_disp", lcd_display_on, 1'b0);

    // Power-up sequence.
    display_on_req = 1'b1;
    @(posedge clock); #1;
    check_eq("pon_disp", lcd_display_on, 1'b1);
    check_eq("pon_ps", power_state, 2'd1);
    check_eq("pon_bl", lcd_backlight, 1'b0);
    wait_ticks(PDT - 1);
    check_eq("pon_wait_ps", power_state, 2'd1);
    check_eq("pon_wait_rdy", ready, 1'b0);
    next_tick();
    check_eq("run_ps", power_state, 2'd2);
    check_eq("run_rdy", ready, 1'b1);

    // Alignment: DE at edge k, red 0x5A at edge k+2 appear together.
    for (int i = 0; i < 3; i++) pix_step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
    pix_step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
    pix_step(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 2'd0, 1'b1);
    check_eq("align_de_low", pix_if.lcd_data_enable, 1'b0);
    check_eq("align_blank", pix_if.lcd_red, 8'h00);
    pix_step(1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
    check_eq("align_de", pix_if.lcd_data_enable, 1'b1);
    check_eq("align_red", pix_if.lcd_red, 8'h5A);

    // Overlay modes with fb=(00,80,FF).
    for (int m = 1; m <= 4; m++) begin
      pix_step(1'b1, 1'b1, 1'b1, 8'h00, 8'h80, 8'hFF, 1'b1, 2'(m % 4), 1'b1);
      check_eq("ovl_mode", {pix_if.lcd_red, pix_if.lcd_green, pix_if.lcd_blue}, ovl_exp[m % 4]);
    end

    rand_steps(40, 1'b1);
    pix_step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);

    // PWM backlight.
    brightness = 4'd5;  wait_pwm(15); count_high(16, 5, "pwm_5");
    brightness = 4'd0;  wait_pwm(15); count_high(16, 0, "pwm_0");
    brightness = 4'd5;  wait_pwm(15); count_high(8, 5, "pwm_first_half");
    brightness = 4'd12; count_high(8, 0, "pwm_mid_change");
    count_high(16, 12, "pwm_12");
    brightness = 4'd15; wait_pwm(15); count_high(16, 16, "pwm_15");

    // Power-down sequence.
    check_eq("bl_on", lcd_backlight, 1'b1);
    display_on_req = 1'b0;
    @(posedge clock); #1;
    check_eq("bloff_bl", lcd_backlight, 1'b0);
    check_eq("bloff_ps", power_state, 2'd3);
    check_eq("bloff_rdy", ready, 1'b0);
    wait_ticks(PDT - 1);
    check_eq("bloff_disp", lcd_display_on, 1'b1);
    next_tick();
    check_eq("pdown_disp", lcd_display_on, 1'b0);
    check_eq("pdown_ps", power_state, 2'd0);

    // Re-request three ticks into backlight-off returns straight to RUN.
    display_on_req = 1'b1;
    @(posedge clock); #1;
    wait_ticks(PDT);
    check_eq("rerun_ps", power_state, 2'd2);
    display_on_req = 1'b0;
    @(posedge clock); #1;
    wait_ticks(3);
    check_eq("bl3_ps", power_state, 2'd3);
    display_on_req = 1'b1;
    @(posedge clock); #1;
    check_eq("resume_ps", power_state, 2'd2);
    check_eq("resume_rdy", ready, 1'b1);
    check_eq("resume_bl", lcd_backlight, 1'b1);

    // Asynchronous reset in the middle of RUN.
    for (int i = 0; i < 3; i++) pix_step(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hC3, 1'b0, 2'd0, 1'b1);
    check_eq("pre_rst_de", pix_if.lcd_data_enable, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("restart_ps", power_state, 2'd1);
    check_eq("restart_disp", lcd_display_on, 1'b1);
    wait_ticks(PDT);
    check_eq("restart_run", power_state, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
